// File: rtl/my_uart_pkg.sv
`timescale 1ns/1ps
// my_uart_pkg: shared constants, FSM state encodings and sizing helpers for the UART echo.
// Ports: none (package).
package my_uart_pkg;

    localparam int unsigned DEF_CLK_HZ     = 50_000_000;
    localparam int unsigned DEF_BAUD       = 9600;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    // Bit period in clocks (truncated) and the mid-bit offset used to centre RX sampling.
    localparam int unsigned DIV      = DEF_CLK_HZ / DEF_BAUD;
    localparam int unsigned HALF_DIV = DIV / 2;

    // FIFO pointer width at the default depth.
    localparam int unsigned PTR_W = $clog2(DEF_FIFO_DEPTH);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    // Bit period for an arbitrary clock / baud pair.
    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

    // Pointer width for a power-of-two FIFO depth.
    function automatic int unsigned calc_ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/my_uart_rx.sv
`timescale 1ns/1ps
// my_uart_rx: 2-flop rxd synchronizer and 8N1 receive FSM.
// Ports: clk       - system clock
//        rst_n     - async active-low reset
//        rxd       - asynchronous serial line, idle high
//        data      - last correctly framed byte
//        valid     - one-clock strobe, high the cycle after a good stop-bit sample
module my_uart_rx
    import my_uart_pkg::*;
#(
    parameter int unsigned BIT_DIV  = DIV,
    parameter int unsigned BIT_HALF = HALF_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid
);

    localparam int unsigned CNT_W = $clog2(BIT_DIV);

    rx_state_e        state_q, state_d;
    logic             sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             rx_s, fall, tick, half_tick;

    assign rx_s      = sync2_q;
    assign fall      = prev_q & ~sync2_q;
    assign tick      = (cnt_q == CNT_W'(BIT_DIV - 1));
    assign half_tick = (cnt_q == CNT_W'(BIT_HALF - 1));

    // Synchronizer plus one delayed copy for falling-edge detection; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RX_IDLE:      if (fall) state_d = RX_START;
            RX_START:     if (half_tick) state_d = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:      if (tick && (bit_q == 3'd7)) state_d = RX_STOP;
            RX_STOP:      if (tick) state_d = rx_s ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (rx_s) state_d = RX_IDLE;
            default:      state_d = RX_IDLE;
        endcase
    end

    // Datapath next values: bit timer, LSB-first shifter, byte/strobe on good stop bit.
    always_comb begin
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
            end
            RX_START: begin
                cnt_d = half_tick ? '0 : cnt_q + CNT_W'(1);
            end
            RX_DATA: begin
                if (tick) begin
                    cnt_d   = '0;
                    bit_d   = bit_q + 3'd1;
                    shift_d = {rx_s, shift_q[7:1]};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (tick) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_WAIT_HIGH: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/my_uart.sv
`timescale 1ns/1ps
// my_uart: 8N1 UART echo -- receiver, byte FIFO, and registered transmitter.
// Ports: clk50m  - system clock
//        reset_n - async active-low reset
//        rxd     - asynchronous serial receive line, idle high
//        txd     - serial transmit line, idle high, driven from a flop
module my_uart
    import my_uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = DEF_CLK_HZ,
    parameter int unsigned BAUD       = DEF_BAUD,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic clk50m,
    input  logic reset_n,
    input  logic rxd,
    output logic txd
);

    localparam int unsigned BIT_DIV  = calc_div(CLK_HZ, BAUD);
    localparam int unsigned BIT_HALF = BIT_DIV / 2;
    localparam int unsigned FPTR_W   = calc_ptr_w(FIFO_DEPTH);
    localparam int unsigned FCNT_W   = FPTR_W + 1;
    localparam int unsigned CNT_W    = $clog2(BIT_DIV);

    logic [7:0] rx_data;
    logic       rx_valid;

    my_uart_rx #(
        .BIT_DIV  (BIT_DIV),
        .BIT_HALF (BIT_HALF)
    ) u_rx (
        .clk   (clk50m),
        .rst_n (reset_n),
        .rxd   (rxd),
        .data  (rx_data),
        .valid (rx_valid)
    );

    // ---------------- FIFO ----------------
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [FPTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [FCNT_W-1:0] count_q;
    logic              fifo_empty, fifo_full, fifo_avail;
    logic              push_ok, pop_ok, tx_pop;
    logic [7:0]        fifo_rd;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FCNT_W'(FIFO_DEPTH));
    // Empty FIFO with a push in flight forwards the incoming byte straight to TX.
    assign fifo_avail = !fifo_empty || rx_valid;
    assign pop_ok     = tx_pop && fifo_avail;
    assign push_ok    = rx_valid && (!fifo_full || pop_ok);
    assign fifo_rd    = fifo_empty ? rx_data : mem_q[rd_ptr_q];

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk50m) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk50m or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + FPTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + FPTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + FCNT_W'(1);
                2'b01:   count_q <= count_q - FCNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ---------------- Transmitter ----------------
    tx_state_e        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             txd_q, txd_d;
    logic             tx_tick;

    assign tx_tick = (tx_cnt_q == CNT_W'(BIT_DIV - 1));

    // State register.
    always_ff @(posedge clk50m or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q <= TX_IDLE;
        end else begin
            tx_state_q <= tx_state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        tx_state_d = tx_state_q;
        unique case (tx_state_q)
            TX_IDLE:  if (fifo_avail) tx_state_d = TX_START;
            TX_START: if (tx_tick) tx_state_d = TX_DATA;
            TX_DATA:  if (tx_tick && (tx_bit_q == 3'd7)) tx_state_d = TX_STOP;
            TX_STOP:  if (tx_tick) tx_state_d = TX_IDLE;
            default:  tx_state_d = TX_IDLE;
        endcase
    end

    // Output logic: pop strobe, bit timer, shifter and next txd level.
    always_comb begin
        tx_pop     = 1'b0;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        unique case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                tx_bit_d = '0;
                txd_d    = 1'b1;
                if (fifo_avail) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = fifo_rd;
                    txd_d      = 1'b0;
                end
            end
            TX_START: begin
                if (tx_tick) begin
                    tx_cnt_d   = '0;
                    txd_d      = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            TX_DATA: begin
                if (tx_tick) begin
                    tx_cnt_d = '0;
                    tx_bit_d = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) begin
                        txd_d = 1'b1;
                    end else begin
                        txd_d      = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            TX_STOP: begin
                tx_cnt_d = tx_tick ? '0 : tx_cnt_q + CNT_W'(1);
            end
            default: begin
                txd_d = 1'b1;
            end
        endcase
    end

    // TX datapath registers; txd resets high.
    always_ff @(posedge clk50m or negedge reset_n) begin
        if (!reset_n) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
        end else begin
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
        end
    end

    assign txd = txd_q;

endmodule

// File: tb/tb_my_uart.sv
`timescale 1ns/1ps
// tb_my_uart: directed echo checks of my_uart with a scaled bit period (32 clocks per bit).
module tb_my_uart;

    localparam int unsigned TB_CLK_HZ = 50_000_000;
    localparam int unsigned TB_BAUD   = 1_562_500;
    localparam int          TB_DIV    = 32;
    localparam int          TB_HALF   = 16;
    localparam int          CLK_PER   = 20;
    localparam int          SB        = 626;   // sender bit time, ~2.2% faster than nominal 640 ns

    logic clk;
    logic rst_n;
    logic rxd;
    logic txd;

    int n_cmp = 0;
    int n_bad = 0;

    my_uart #(
        .CLK_HZ     (TB_CLK_HZ),
        .BAUD       (TB_BAUD),
        .FIFO_DEPTH (4)
    ) dut (
        .clk50m  (clk),
        .reset_n (rst_n),
        .rxd     (rxd),
        .txd     (txd)
    );

    initial clk = 1'b0;
    always #(CLK_PER / 2) clk = ~clk;

    // Line monitor: decodes each txd frame and checks every bit is flat across its window.
    typedef struct {
        logic [7:0] data;
        logic       good;
        time        t_start;
    } frame_t;

    frame_t     mon_q[$];
    int         mon_starts  = 0;
    int         mon_aborted = 0;
    logic [9:0] mon_bits;
    logic       mon_ref;
    logic       mon_shape;
    logic       mon_abort;
    time        mon_ts;
    frame_t     mon_f;

    always begin
        @(negedge txd);
        mon_ts    = $time;
        mon_starts++;
        mon_shape = 1'b1;
        mon_abort = 1'b0;
        mon_bits  = '0;
        for (int i = 0; i < 10 * TB_DIV; i++) begin
            @(negedge clk);
            if (!rst_n) mon_abort = 1'b1;
            if ((i % TB_DIV) == 0) begin
                mon_ref = txd;
                mon_bits[4'(i / TB_DIV)] = txd;
            end else if (txd !== mon_ref) begin
                mon_shape = 1'b0;
            end
        end
        if (mon_abort) begin
            mon_aborted++;
        end else begin
            mon_f.data    = mon_bits[8:1];
            mon_f.good    = mon_shape && (mon_bits[0] == 1'b0) && (mon_bits[9] == 1'b1);
            mon_f.t_start = mon_ts;
            mon_q.push_back(mon_f);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input longint obs, input longint lo, input longint hi);
        n_cmp++;
        assert (obs >= lo && obs <= hi) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Puts the next rxd edges on odd ns so they never coincide with a clock edge.
    task automatic align();
        @(posedge clk);
        #3;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, output time t0);
        t0  = $time;
        rxd = 1'b0;
        #SB;
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            #SB;
        end
        rxd = stop;
        #SB;
    endtask

    task automatic idle_bits(input int n);
        rxd = 1'b1;
        #(SB * n);
    endtask

    task automatic wait_frames(input string tag, input int n);
        int k = 0;
        while (mon_q.size() < n && k < 20000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(mon_q.size()), 32'(n));
    endtask

    // Pops one decoded frame; optionally checks rx-start-edge to tx-start-edge latency.
    // Nominal: ~3 clocks detect + HALF + 9*DIV to the stop sample, then at most 3 clocks.
    task automatic check_frame(input string tag, input logic [7:0] exp, input bit lat, input time t0);
        frame_t f;
        if (mon_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s_present: observed no frame expected 0x%0h", tag, exp);
        end else begin
            f = mon_q.pop_front();
            chk({tag, "_data"}, 32'(f.data), 32'(exp));
            chk({tag, "_shape"}, 32'(f.good), 32'd1);
            if (lat) begin
                chk_range({tag, "_latency_ns"}, longint'(f.t_start - t0),
                          longint'((TB_HALF + 9 * TB_DIV) * CLK_PER),
                          longint'((TB_HALF + 9 * TB_DIV + 7) * CLK_PER));
            end
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        time t_a, t_b, t_c, t_x;
        int  starts0;
        logic [7:0] burst [8];

        burst[0] = 8'h00; burst[1] = 8'hFF; burst[2] = 8'h55; burst[3] = 8'hAA;
        burst[4] = 8'h01; burst[5] = 8'h80; burst[6] = 8'h7E; burst[7] = 8'h81;

        // Reset held 10 us, then idle line.
        rst_n = 1'b0;
        rxd   = 1'b1;
        #5001;
        chk("reset_txd", 32'(txd), 32'd1);
        #5002;
        rst_n = 1'b1;
        #4000;
        chk("idle_txd", 32'(txd), 32'd1);
        chk("idle_no_activity", 32'(mon_starts), 32'd0);

        // Three bytes with one idle bit between.
        align();
        send_byte(8'h48, 1'b1, t_a); idle_bits(1);
        send_byte(8'h49, 1'b1, t_b); idle_bits(1);
        send_byte(8'h20, 1'b1, t_c); idle_bits(1);
        wait_frames("hi_count", 3);
        check_frame("hi0", 8'h48, 1'b1, t_a);
        check_frame("hi1", 8'h49, 1'b1, t_b);
        check_frame("hi2", 8'h20, 1'b1, t_c);

        // 20 us break then a valid byte.
        align();
        starts0 = mon_starts;
        rxd = 1'b0;
        #20000;
        idle_bits(3);
        chk("break_no_echo", 32'(mon_starts - starts0), 32'd0);
        send_byte(8'h55, 1'b1, t_a); idle_bits(1);
        wait_frames("break_next_count", 1);
        check_frame("break_next", 8'h55, 1'b1, t_a);

        // Framing error then a valid byte.
        align();
        starts0 = mon_starts;
        send_byte(8'hA5, 1'b0, t_x); idle_bits(1);
        idle_bits(2);
        chk("ferr_no_echo", 32'(mon_starts - starts0), 32'd0);
        send_byte(8'h3C, 1'b1, t_a); idle_bits(1);
        wait_frames("ferr_next_count", 1);
        check_frame("ferr_next", 8'h3C, 1'b1, t_a);

        // Eight frames back to back with zero idle time.
        align();
        for (int i = 0; i < 8; i++) begin
            send_byte(burst[i], 1'b1, t_x);
        end
        idle_bits(2);
        wait_frames("burst_count", 8);
        for (int i = 0; i < 8; i++) begin
            check_frame($sformatf("burst%0d", i), burst[i], 1'b0, t_x);
        end

        // Reset asserted while 0x48 is being echoed.
        align();
        starts0 = mon_starts;
        send_byte(8'h48, 1'b1, t_x);
        chk("abort_echo_started", 32'(mon_starts - starts0), 32'd1);
        #(3 * 640);
        chk("abort_pre_txd", 32'(txd), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_async_txd", 32'(txd), 32'd1);
        #999;
        chk("abort_hold_txd", 32'(txd), 32'd1);
        rst_n = 1'b1;
        #(20 * 640);
        chk("abort_flagged", 32'(mon_aborted), 32'd1);
        chk("abort_no_partial", 32'(mon_q.size()), 32'd0);
        chk("abort_no_restart", 32'(mon_starts - starts0), 32'd1);
        chk("abort_idle_txd", 32'(txd), 32'd1);
        align();
        send_byte(8'h49, 1'b1, t_a); idle_bits(1);
        wait_frames("abort_next_count", 1);
        check_frame("abort_next", 8'h49, 1'b1, t_a);
        #(12 * 640);
        chk("abort_next_alone", 32'(mon_starts - starts0), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/my_uart.md
MY_UART -- requirements
Module: my_uart

Interface
REQ-001 Parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line rate in bits per second.
REQ-003 Parameter FIFO_DEPTH, default 4, receive-to-transmit byte buffer depth; SHALL be a power of two.
REQ-004 clk50m  input  1  single system clock; all logic on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 rxd  input  1  asynchronous serial receive line; idle high.
REQ-007 txd  output  1  serial transmit line; idle high.

Function
REQ-008 Block SHALL be a UART echo: every byte correctly received on rxd SHALL be retransmitted unchanged on txd, in arrival order.
REQ-009 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, no parity, one stop bit 1.
REQ-010 Bit period SHALL be DIV = CLK_HZ/BAUD clocks, truncated (5208 at defaults).
REQ-011 rxd SHALL pass through a 2-flop synchronizer before any use.
REQ-012 RX states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-013 IDLE->START on synchronized rxd high-to-low transition.
REQ-014 START: at DIV/2 clocks, rxd low -> DATA; rxd high -> IDLE (false start, nothing stored).
REQ-015 DATA: sample every DIV clocks from the mid-start point; 8 samples shift into the byte LSB first.
REQ-016 STOP: sample DIV clocks after bit 7; 1 -> push byte to FIFO and go to IDLE in the same cycle; 0 -> framing error, discard byte, go to WAIT_HIGH.
REQ-017 WAIT_HIGH -> IDLE once synchronized rxd is 1.
REQ-018 Because RX re-arms at mid-stop, it SHALL accept back-to-back frames with zero idle time and sender bit periods within +/-3% of nominal.
REQ-019 FIFO: synchronous, FIFO_DEPTH entries, wrap-around pointers, count of width log2(FIFO_DEPTH)+1; push when full drops the new byte and keeps contents; simultaneous push and pop with FIFO full or empty SHALL both succeed in a single cycle.
REQ-020 TX states: IDLE, START, DATA, STOP.
REQ-021 TX IDLE with FIFO non-empty: pop, load shift register, drive txd=0 on the next clock; each bit held exactly DIV clocks.
REQ-022 After the stop bit, TX returns to IDLE and SHALL begin the next start bit within 2 clocks if the FIFO is non-empty.
REQ-023 Latency: txd start edge SHALL occur no more than 3 clocks after the RX stop-bit sample when TX is idle.
REQ-024 txd SHALL be driven from a register (no combinational glitches).

Reset
REQ-025 While reset_n=0: txd=1, both FSMs in IDLE, FIFO empty, counters and shift registers 0, synchronizer flops 1.
REQ-026 Reset mid-frame SHALL abort both directions immediately; after release the block SHALL wait for a fresh falling edge on rxd and SHALL NOT emit partial frames.

Structure
REQ-027 Package my_uart_pkg SHALL hold DIV, HALF_DIV, the RX and TX state enums and the FIFO pointer width.
REQ-028 The receiver SHALL be one sub-module, my_uart_rx (synchronizer, RX FSM, byte/valid output); the FIFO and transmitter SHALL reside in my_uart.

Verification
REQ-029 Reset held 10 us, then released -> txd stays 1, no activity while rxd idle.
REQ-030 Send 0x48, 0x49, 0x20 at 102000 ns bit time with 1 idle bit between -> txd carries 0x48, 0x49, 0x20 in order, each frame 10 x 5208 clocks, start within 3 clocks of each RX stop sample.
REQ-031 rxd low for 20 us, then high -> no byte echoed; next valid 0x55 echoes correctly.
REQ-032 Frame 0xA5 with stop bit 0, then rxd high 1 bit -> nothing echoed; following 0x3C echoes as 0x3C.
REQ-033 Eight back-to-back frames (0x00, 0xFF, 0x55, 0xAA, 0x01, 0x80, 0x7E, 0x81) with zero idle at 102000 ns bit time -> all eight echoed, in order, no loss.
REQ-034 Assert reset_n=0 mid-way through echoing 0x48 -> txd=1 asynchronously, FIFO empty; after release, 0x49 echoes alone.
